// File: rtl/taillight_seq.sv
// taillight_seq: rear-lamp sequencer for the turn, brake and hazard light path.
//   It contains the state register, the animation tick divider and the step
//   counter. Every output is registered, so a request sampled at an edge shows
//   on the lamps right after that edge.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   left_req   left turn request (level)
//   right_req  right turn request (level)
//   haz_req    hazard request (level)
//   brake_req  brake request (level)
//   lamp_l     left lamps, bit 0 innermost, 1 = lit
//   lamp_r     right lamps, bit 0 innermost, 1 = lit
//   state      current state code (debug)
//   tick       one-cycle animation-step strobe (debug)
module taillight_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 12500000,
  parameter int DIV_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             haz_req,
  input  logic             brake_req,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic [2:0]       state,
  output logic             tick
);

  localparam int SW = $clog2(LAMPS + 1);

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] LEFT   = 3'b001;
  localparam logic [2:0] RIGHT  = 3'b010;
  localparam logic [2:0] LFIN   = 3'b011;
  localparam logic [2:0] RFIN   = 3'b100;
  localparam logic [2:0] HAZARD = 3'b101;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_MAX = SW'(LAMPS);
  localparam logic [LAMPS-1:0] ALL_ON   = '1;

  logic [2:0]       st_q, st_n;
  logic [DIV_W-1:0] div_q, div_n, div_inc;
  logic [SW-1:0]    step_q, step_n, step_inc, step_adv;
  logic             phase_q, phase_n;
  logic             adv, haz;
  logic [LAMPS-1:0] lamp_l_n, lamp_r_n, therm, brk;
  logic             tick_n;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      div_q   <= '0;
      step_q  <= '0;
      phase_q <= 1'b0;
      tick    <= 1'b0;
      lamp_l  <= '0;
      lamp_r  <= '0;
    end else begin
      st_q    <= st_n;
      div_q   <= div_n;
      step_q  <= step_n;
      phase_q <= phase_n;
      tick    <= tick_n;
      lamp_l  <= lamp_l_n;
      lamp_r  <= lamp_r_n;
    end
  end

  assign state    = st_q;
  // adv marks the cycle whose closing edge is an animation step.
  assign adv      = (div_q == DIV_LAST);
  assign div_inc  = adv ? '0 : div_q + 1'b1;
  assign step_inc = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
  assign step_adv = adv ? step_inc : step_q;
  assign haz      = haz_req | (left_req & right_req);

  // next-state
  always_comb begin
    st_n    = IDLE;
    div_n   = '0;
    step_n  = '0;
    phase_n = 1'b0;
    if (haz) begin
      st_n = HAZARD;
      if (st_q == HAZARD) begin
        div_n   = div_inc;
        phase_n = adv ? ~phase_q : phase_q;
      end else begin
        phase_n = 1'b1;
      end
    end else if (left_req) begin
      st_n = LEFT;
      // Re-request during the finish sweep continues seamlessly.
      if (st_q == LEFT || st_q == LFIN) begin
        div_n  = div_inc;
        step_n = step_adv;
      end else begin
        step_n = SW'(1);
      end
    end else if (right_req) begin
      st_n = RIGHT;
      if (st_q == RIGHT || st_q == RFIN) begin
        div_n  = div_inc;
        step_n = step_adv;
      end else begin
        step_n = SW'(1);
      end
    end else if (st_q == LEFT || st_q == LFIN || st_q == RIGHT || st_q == RFIN) begin
      // Finish sweep: keep stepping until the pattern wraps back to dark.
      if (step_q != '0 && step_adv != '0) begin
        st_n   = (st_q == LEFT || st_q == LFIN) ? LFIN : RFIN;
        div_n  = div_inc;
        step_n = step_adv;
      end
    end
  end

  // outputs, derived from next-state so lamps land with the state change
  always_comb begin
    for (int i = 0; i < LAMPS; i++) therm[i] = (i < int'(step_n));
    brk      = brake_req ? ALL_ON : '0;
    lamp_l_n = '0;
    lamp_r_n = '0;
    tick_n   = (div_n == DIV_LAST);
    case (st_n)
      IDLE:        begin lamp_l_n = brk;   lamp_r_n = brk;   end
      LEFT, LFIN:  begin lamp_l_n = therm; lamp_r_n = brk;   end
      RIGHT, RFIN: begin lamp_l_n = brk;   lamp_r_n = therm; end
      HAZARD: begin
        lamp_l_n = phase_n ? ALL_ON : '0;
        lamp_r_n = phase_n ? ALL_ON : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/taillight_seq.md
Name: taillight_seq

Overview:
- Parametrised rear-lamp sequencer for the turn/brake/hazard light path. It is the next generation of the combinational next-state/counter-reset logic.
- It absorbs the state register, the animation tick divider and the step counter into one clocked block. It drives per-lamp outputs directly.
- It adds N lamps per side, brake overlay on the non-turning side, and "finish-sweep" behaviour when a turn request drops mid-sequence.
- It sits between the debounced switch/key inputs and the lamp output pins.

Parameters:
- LAMPS, 3, lamps per side (>=2); bit 0 is the innermost lamp.
- TICK_DIV, 12500000, clk cycles per animation step (>=2).
- DIV_W, 24, width of the divider counter; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- left_req  input  1  left turn request, level.
- right_req  input  1  right turn request, level.
- haz_req  input  1  hazard request, level.
- brake_req  input  1  brake request, level.
- lamp_l  output  LAMPS  left lamps, 1 = lit.
- lamp_r  output  LAMPS  right lamps, 1 = lit.
- state  output  3  current state code, for debug/LEDs.
- tick  output  1  one-cycle animation-step strobe, for debug.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE(000), divider=0, step=0, phase=0, tick=0, lamp_l=0, lamp_r=0.
- States: IDLE=000, LEFT=001, RIGHT=010, LFIN=011, RFIN=100, HAZARD=101.
- All outputs are registered. A request change sampled at edge N is visible on the lamps after edge N (1-cycle latency).
- Request priority, highest first:
  - haz_req, or left_req and right_req together -> HAZARD.
  - left_req -> LEFT.
  - right_req -> RIGHT.
  - No request -> finish/idle rules below.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for the cycle in which the divider equals TICK_DIV-1.
  - Divider clears to 0 on any entry to LEFT, RIGHT or HAZARD from a different direction or mode.
- Step counter (LEFT/RIGHT/LFIN/RFIN):
  - Range 0..LAMPS.
  - On entry to LEFT/RIGHT, step is set to 1.
  - On each tick, step increments; LAMPS+1 wraps to 0.
- Turn lamps: the turning side lights bits [step-1:0] (step=0 means all off). The sequence with LAMPS=3 is 001, 011, 111, 000, 001, ...
- HAZARD:
  - On entry, phase=1; phase toggles on each tick.
  - Both sides show all-ones when phase=1 and all-zeros when phase=0.
  - brake_req is ignored in HAZARD.
- Brake overlay: in IDLE with brake_req=1, both sides are all-ones. In LEFT/LFIN the right side is all-ones while brake_req=1, and symmetrically for RIGHT/RFIN.
- Idle lamps: IDLE with brake_req=0 gives both sides zero.
- Finish sweep, when left_req drops in LEFT with no other request:
  - If step==0, go to IDLE.
  - Otherwise go to LFIN; stepping continues with the divider not cleared.
  - On the tick where step wraps LAMPS -> 0, go to IDLE.
  - RFIN is symmetric.
- Re-request during finish:
  - left_req re-asserted in LFIN -> LEFT, with step and divider unchanged (seamless).
  - right_req in LFIN -> RIGHT with step=1 and divider cleared.
  - haz_req in any state -> HAZARD immediately.
- Leaving HAZARD: with a turn request active, go to that turn state with step=1. Otherwise go to IDLE immediately, with no finish on hazard.
- Direction change: LEFT -> RIGHT switches immediately. The left lamps go off, or to all-ones if brake_req=1.
- Reset mid-operation: all registers return to reset values on the next edge, regardless of state.

Test Plan (LAMPS=3, TICK_DIV=4):
- Reset: rst_n=0 for 2 cycles with all requests high -> lamp_l=lamp_r=000, state=000, tick=0. After release with requests low, the outputs stay at 0.
- Left sweep: left_req=1 held -> lamp_l=001 one cycle after sampling. It then steps 011, 111, 000, 001 every 4 cycles, with lamp_r=000 throughout.
- Finish sweep: left_req dropped while lamp_l=011 -> state=011 (LFIN). The lamps go 111 then 000 on successive ticks, then state=000. No further lamp activity follows.
- Hazard override plus brake: right_req=1, brake_req=1, then haz_req=1 mid-sweep -> both sides 111 next cycle, then 000/111 alternating every 4 cycles. Dropping haz_req with right_req=1 gives lamp_r=001 and lamp_l=111.
- Both turns: left_req=right_req=1 -> state=101 with the hazard flash. Dropping right_req gives state=001 and lamp_l=001.
- Reset mid-operation: rst_n=0 during RFIN with lamp_r=011 -> all outputs 0 after the edge. After release with right_req=1, lamp_r=001 is seen after the first edge and the divider restarts from 0.
